// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-master RAM arbiter.
package ram_arbiter_pkg;

    // Arbiter state: IDLE evaluates requests, GNT carries one transaction.
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_GNT  = 1'b1
    } arb_state_e;

    // Master indices, used for grant and last-served bookkeeping.
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

endpackage

// File: rtl/ram_arbiter_if.sv
// Valid/ready word-memory bus shared by both masters and the RAM side.
// A wstrb of zero marks a read; rdata is meaningful while ready is high.
interface ram_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic [31:0]       rdata;
    logic              ready;

    // Requester side: presents the access and waits for ready.
    modport master (
        output valid, addr, wdata, wstrb,
        input  rdata, ready
    );

    // Responder side: accepts the access and returns ready/rdata.
    modport slave (
        input  valid, addr, wdata, wstrb,
        output rdata, ready
    );
endinterface

// File: rtl/ram_arbiter_arb_pick2.sv
// Two-way request picker: a lone requester always wins; a tie goes to m0
// under fixed priority, otherwise to the master not served most recently.
module arb_pick2
    import ram_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    input  logic       fixed_prio_i,
    output logic       winner_o
);

    // Winner selection; an empty request vector defaults to m0 (unused).
    always_comb begin
        winner_o = M0;
        case (req_i)
            2'b01:   winner_o = M0;
            2'b10:   winner_o = M1;
            2'b11:   winner_o = fixed_prio_i ? M0 : ~last_i;
            default: winner_o = M0;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port word RAM between two valid/ready masters.
// One transaction is in flight at a time; the grant is registered in IDLE
// and held for the whole GNT phase, so a zero-wait RAM gives one access
// every two cycles.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ARB_IDLE | no access on the RAM bus; pending requests are arbitrated
// ARB_GNT  | granted master is routed to the RAM until ready or drop
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic          clk_sys_i,
    input  logic          rst_i,
    ram_arbiter_if.slave  m0_io,
    ram_arbiter_if.slave  m1_io,
    ram_arbiter_if.master mem_io
);

    arb_state_e state_q;
    logic       grant_q;
    logic       last_q;

    logic [1:0]        req;
    logic              winner;
    logic              active;
    logic              sel_valid;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [3:0]        sel_wstrb;
    logic              done;

    assign req = {m1_io.valid, m0_io.valid};

    arb_pick2 u_pick (
        .req_i        (req),
        .last_i       (last_q),
        .fixed_prio_i (FIXED_PRIO),
        .winner_o     (winner)
    );

    // Route the granted master's request fields toward the RAM.
    always_comb begin
        sel_valid = m0_io.valid;
        sel_addr  = m0_io.addr;
        sel_wdata = m0_io.wdata;
        sel_wstrb = m0_io.wstrb;
        if (grant_q == M1) begin
            sel_valid = m1_io.valid;
            sel_addr  = m1_io.addr;
            sel_wdata = m1_io.wdata;
            sel_wstrb = m1_io.wstrb;
        end
    end

    // Reset gates the bus combinationally so a reset cycle can never write.
    assign active = (state_q == ARB_GNT) && !rst_i;
    assign done   = mem_io.valid && mem_io.ready;

    assign mem_io.valid = active && sel_valid;
    assign mem_io.addr  = sel_addr;
    assign mem_io.wdata = sel_wdata;
    assign mem_io.wstrb = sel_wstrb;

    assign m0_io.ready = done && (grant_q == M0);
    assign m1_io.ready = done && (grant_q == M1);
    assign m0_io.rdata = mem_io.rdata;
    assign m1_io.rdata = mem_io.rdata;

    // Arbitration FSM: grant in IDLE, release on completion or abandonment.
    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
            grant_q <= M0;
            last_q  <= M1;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (req != 2'b00) begin
                        grant_q <= winner;
                        state_q <= ARB_GNT;
                    end
                end
                ARB_GNT: begin
                    // A dropped request is abandoned without touching the
                    // fairness history.
                    if (!sel_valid) begin
                        state_q <= ARB_IDLE;
                    end else if (mem_io.ready) begin
                        last_q  <= grant_q;
                        state_q <= ARB_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a round-robin instance backed by a small
// byte-writable RAM model with programmable wait states, plus a
// fixed-priority instance backed by an always-ready dummy memory.
module tb_ram_arbiter;

    logic clk_sys = 1'b0;
    logic rst;

    always #5 clk_sys = ~clk_sys;

    ram_arbiter_if #(.ADDR_W(32)) m0_if ();
    ram_arbiter_if #(.ADDR_W(32)) m1_if ();
    ram_arbiter_if #(.ADDR_W(32)) mem_if ();
    ram_arbiter_if #(.ADDR_W(32)) fp_m0_if ();
    ram_arbiter_if #(.ADDR_W(32)) fp_m1_if ();
    ram_arbiter_if #(.ADDR_W(32)) fp_mem_if ();

    ram_arbiter #(.ADDR_W(32), .FIXED_PRIO(1'b0)) dut (
        .clk_sys_i (clk_sys),
        .rst_i     (rst),
        .m0_io     (m0_if),
        .m1_io     (m1_if),
        .mem_io    (mem_if)
    );

    ram_arbiter #(.ADDR_W(32), .FIXED_PRIO(1'b1)) dut_fp (
        .clk_sys_i (clk_sys),
        .rst_i     (rst),
        .m0_io     (fp_m0_if),
        .m1_io     (fp_m1_if),
        .mem_io    (fp_mem_if)
    );

    assign fp_mem_if.ready = fp_mem_if.valid;
    assign fp_mem_if.rdata = 32'h0;

    // RAM model: 16 words, combinational read, byte-enabled write on accept.
    logic [31:0] ram [0:15];
    logic        load_en = 1'b0;
    logic [3:0]  load_idx = 4'd0;
    logic [31:0] load_data = 32'h0;
    int unsigned wait_cfg = 0;
    int unsigned wait_ctr = 0;

    assign mem_if.rdata = ram[mem_if.addr[5:2]];
    assign mem_if.ready = mem_if.valid && (wait_ctr >= wait_cfg);

    always @(posedge clk_sys) begin
        if (load_en) begin
            ram[load_idx] <= load_data;
        end else if (mem_if.valid && mem_if.ready) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_if.wstrb[b]) ram[mem_if.addr[5:2]][8*b +: 8] <= mem_if.wdata[8*b +: 8];
            end
        end
        if (mem_if.valid && !mem_if.ready) wait_ctr <= wait_ctr + 1;
        else wait_ctr <= 0;
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic cyc();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic load_word(input logic [3:0] idx, input logic [31:0] data);
        load_en   = 1'b1;
        load_idx  = idx;
        load_data = data;
        cyc();
        load_en = 1'b0;
    endtask

    task automatic drive_m0(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        m0_if.valid = v; m0_if.addr = a; m0_if.wdata = d; m0_if.wstrb = s;
    endtask

    task automatic drive_m1(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        m1_if.valid = v; m1_if.addr = a; m1_if.wdata = d; m1_if.wstrb = s;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_m0(1'b1, 32'h10, 32'h0, 4'hF);
        cyc(); #1;
        n_total++;
        if (mem_if.valid !== 1'b0) $display("FAIL reset_mem_valid: got %b want 0", mem_if.valid);
        else n_pass++;
        n_total++;
        if (m0_if.ready !== 1'b0) $display("FAIL reset_m0_ready: got %b want 0", m0_if.ready);
        else n_pass++;
        drive_m0(1'b0, 32'h0, 32'h0, 4'h0);
        cyc();
        rst = 1'b0;
        #1;
        n_total++;
        if ({mem_if.valid, m0_if.ready, m1_if.ready} !== 3'b000)
            $display("FAIL reset_idle_outputs: got %b want 000", {mem_if.valid, m0_if.ready, m1_if.ready});
        else n_pass++;
    endtask

    task automatic test_single_read();
        cyc();
        drive_m0(1'b1, 32'h10, 32'h0, 4'h0);
        #1;
        n_total++;
        if ({mem_if.valid, m0_if.ready} !== 2'b00) $display("FAIL read_cycle_n: got %b want 00", {mem_if.valid, m0_if.ready});
        else n_pass++;
        cyc(); #1;
        n_total++;
        if (m0_if.ready !== 1'b1) $display("FAIL read_ready: got %b want 1", m0_if.ready);
        else n_pass++;
        n_total++;
        if (m0_if.rdata !== 32'hDEADBEEF) $display("FAIL read_rdata: got %h want deadbeef", m0_if.rdata);
        else n_pass++;
        n_total++;
        if (m1_if.ready !== 1'b0) $display("FAIL read_m1_ready: got %b want 0", m1_if.ready);
        else n_pass++;
        n_total++;
        if (mem_if.addr !== 32'h10) $display("FAIL read_addr: got %h want 00000010", mem_if.addr);
        else n_pass++;
        cyc();
        drive_m0(1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        n_total++;
        if ({mem_if.valid, m0_if.ready} !== 2'b00) $display("FAIL read_back_idle: got %b want 00", {mem_if.valid, m0_if.ready});
        else n_pass++;
    endtask

    task automatic test_byte_write();
        cyc();
        drive_m1(1'b1, 32'h8, 32'h11223344, 4'b0010);
        #1;
        n_total++;
        if (mem_if.valid !== 1'b0) $display("FAIL bw_cycle_n_valid: got %b want 0", mem_if.valid);
        else n_pass++;
        cyc(); #1;
        n_total++;
        if ({mem_if.valid, mem_if.wstrb} !== 5'b1_0010) $display("FAIL bw_strobe: got %b want 10010", {mem_if.valid, mem_if.wstrb});
        else n_pass++;
        n_total++;
        if (mem_if.wdata !== 32'h11223344) $display("FAIL bw_wdata: got %h want 11223344", mem_if.wdata);
        else n_pass++;
        n_total++;
        if ({m1_if.ready, m0_if.ready} !== 2'b10) $display("FAIL bw_ready: got %b want 10", {m1_if.ready, m0_if.ready});
        else n_pass++;
        cyc();
        drive_m1(1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        n_total++;
        if ({mem_if.valid, m1_if.ready} !== 2'b00) $display("FAIL bw_single_cycle: got %b want 00", {mem_if.valid, m1_if.ready});
        else n_pass++;
        cyc();
        drive_m0(1'b1, 32'h8, 32'h0, 4'h0);
        cyc(); #1;
        n_total++;
        if ({m0_if.ready, m0_if.rdata} !== {1'b1, 32'hAABB33DD})
            $display("FAIL bw_readback: got ready=%b data=%h want ready=1 data=aabb33dd", m0_if.ready, m0_if.rdata);
        else n_pass++;
        cyc();
        drive_m0(1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic test_contention();
        logic exp_m0, exp_m1, exp_f0;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        drive_m0(1'b1, 32'h10, 32'h0, 4'h0);
        drive_m1(1'b1, 32'h8, 32'h0, 4'h0);
        fp_m0_if.valid = 1'b1; fp_m0_if.addr = 32'h0; fp_m0_if.wdata = 32'h0; fp_m0_if.wstrb = 4'h0;
        fp_m1_if.valid = 1'b1; fp_m1_if.addr = 32'h4; fp_m1_if.wdata = 32'h0; fp_m1_if.wstrb = 4'h0;
        for (int c = 0; c < 8; c++) begin
            #1;
            exp_m0 = (c == 1) || (c == 5);
            exp_m1 = (c == 3) || (c == 7);
            exp_f0 = (c % 2) == 1;
            n_total++;
            if ({m0_if.ready, m1_if.ready} !== {exp_m0, exp_m1})
                $display("FAIL rr_order c%0d: got %b%b want %b%b", c, m0_if.ready, m1_if.ready, exp_m0, exp_m1);
            else n_pass++;
            n_total++;
            if ({fp_m0_if.ready, fp_m1_if.ready} !== {exp_f0, 1'b0})
                $display("FAIL fp_order c%0d: got %b%b want %b0", c, fp_m0_if.ready, fp_m1_if.ready, exp_f0);
            else n_pass++;
            cyc();
        end
        drive_m0(1'b0, 32'h0, 32'h0, 4'h0);
        drive_m1(1'b0, 32'h0, 32'h0, 4'h0);
        fp_m0_if.valid = 1'b0;
        fp_m1_if.valid = 1'b0;
    endtask

    task automatic test_wait_states();
        logic exp_rdy;
        wait_cfg = 3;
        cyc();
        drive_m0(1'b1, 32'h14, 32'hCAFEF00D, 4'hF);
        #1;
        n_total++;
        if (mem_if.valid !== 1'b0) $display("FAIL ws_cycle_n_valid: got %b want 0", mem_if.valid);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (k == 1) drive_m1(1'b1, 32'h8, 32'h0, 4'h0);
            #1;
            exp_rdy = (k == 3);
            n_total++;
            if ({mem_if.valid, mem_if.addr, mem_if.wdata} !== {1'b1, 32'h14, 32'hCAFEF00D})
                $display("FAIL ws_stable k%0d: got v=%b a=%h d=%h want v=1 a=00000014 d=cafef00d", k, mem_if.valid, mem_if.addr, mem_if.wdata);
            else n_pass++;
            n_total++;
            if ({m0_if.ready, m1_if.ready} !== {exp_rdy, 1'b0})
                $display("FAIL ws_ready k%0d: got %b%b want %b0", k, m0_if.ready, m1_if.ready, exp_rdy);
            else n_pass++;
        end
        cyc();
        drive_m0(1'b0, 32'h0, 32'h0, 4'h0);
        wait_cfg = 0;
        #1;
        n_total++;
        if ({mem_if.valid, m1_if.ready} !== 2'b00) $display("FAIL ws_idle_after: got %b want 00", {mem_if.valid, m1_if.ready});
        else n_pass++;
        cyc(); #1;
        n_total++;
        if ({m1_if.ready, mem_if.addr, m1_if.rdata} !== {1'b1, 32'h8, 32'hAABB33DD})
            $display("FAIL ws_pending_m1: got r=%b a=%h d=%h want r=1 a=00000008 d=aabb33dd", m1_if.ready, mem_if.addr, m1_if.rdata);
        else n_pass++;
        cyc();
        drive_m1(1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic test_reset_mid();
        cyc();
        drive_m1(1'b1, 32'h18, 32'hFFFFFFFF, 4'hF);
        cyc();
        rst = 1'b1;
        #1;
        n_total++;
        if ({mem_if.valid, m1_if.ready} !== 2'b00) $display("FAIL rmid_gated: got %b want 00", {mem_if.valid, m1_if.ready});
        else n_pass++;
        cyc();
        rst = 1'b0;
        drive_m1(1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        n_total++;
        if ({mem_if.valid, m1_if.ready} !== 2'b00) $display("FAIL rmid_idle: got %b want 00", {mem_if.valid, m1_if.ready});
        else n_pass++;
        cyc();
        drive_m1(1'b1, 32'h18, 32'h0, 4'h0);
        cyc(); #1;
        n_total++;
        if ({m1_if.ready, m1_if.rdata} !== {1'b1, 32'h01020304})
            $display("FAIL rmid_word_kept: got r=%b d=%h want r=1 d=01020304", m1_if.ready, m1_if.rdata);
        else n_pass++;
        cyc();
        drive_m1(1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic test_abandon();
        cyc();
        drive_m0(1'b1, 32'h10, 32'h0, 4'hF);
        cyc();
        drive_m0(1'b0, 32'h10, 32'h0, 4'hF);
        #1;
        n_total++;
        if ({mem_if.valid, m0_if.ready} !== 2'b00) $display("FAIL ab_no_access: got %b want 00", {mem_if.valid, m0_if.ready});
        else n_pass++;
        cyc(); #1;
        n_total++;
        if ({mem_if.valid, m0_if.ready} !== 2'b00) $display("FAIL ab_idle: got %b want 00", {mem_if.valid, m0_if.ready});
        else n_pass++;
        drive_m0(1'b1, 32'h10, 32'h0, 4'h0);
        drive_m1(1'b1, 32'h8, 32'h0, 4'h0);
        cyc(); #1;
        n_total++;
        if ({m0_if.ready, m1_if.ready} !== 2'b10) $display("FAIL ab_tie_winner: got %b want 10", {m0_if.ready, m1_if.ready});
        else n_pass++;
        n_total++;
        if (m0_if.rdata !== 32'hDEADBEEF) $display("FAIL ab_word_kept: got %h want deadbeef", m0_if.rdata);
        else n_pass++;
        cyc();
        drive_m0(1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        n_total++;
        if (mem_if.valid !== 1'b0) $display("FAIL ab_gap: got %b want 0", mem_if.valid);
        else n_pass++;
        cyc(); #1;
        n_total++;
        if (m1_if.ready !== 1'b1) $display("FAIL ab_m1_served: got %b want 1", m1_if.ready);
        else n_pass++;
        cyc();
        drive_m1(1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    initial begin
        rst = 1'b1;
        drive_m0(1'b0, 32'h0, 32'h0, 4'h0);
        drive_m1(1'b0, 32'h0, 32'h0, 4'h0);
        fp_m0_if.valid = 1'b0; fp_m0_if.addr = 32'h0; fp_m0_if.wdata = 32'h0; fp_m0_if.wstrb = 4'h0;
        fp_m1_if.valid = 1'b0; fp_m1_if.addr = 32'h0; fp_m1_if.wdata = 32'h0; fp_m1_if.wstrb = 4'h0;
        load_word(4'd4, 32'hDEADBEEF);
        load_word(4'd2, 32'hAABBCCDD);
        load_word(4'd5, 32'h00000000);
        load_word(4'd6, 32'h01020304);
        test_reset();
        test_single_read();
        test_byte_write();
        test_contention();
        test_wait_states();
        test_reset_mid();
        test_abandon();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
